// File: rtl/hood_button_encoder.sv
// -----------------------------------------------------------------------------
// hood_button_encoder
//
// Turns the raw, bouncy push-buttons of a cooker hood front panel into clean
// control levels for the hood controller. Everything runs on the 100 Hz tick.
//
//   menu button : short press (power on)  -> MENU_PULSE_TICKS wide menu pulse
//                 short press (power off) -> ignored
//                 long press              -> toggles power_on, one-tick long_press
//   mode buttons: a clean single-button press latches a one-hot mode while the
//                 hood is powered; powering off clears the mode.
//
// Ports
//   clk_100Hz       in   sole clock, rising edge
//   reset           in   asynchronous, active-high
//   btn_menu_raw    in   raw menu button, active-high
//   btn_mode_raw    in   [3:0] raw mode buttons (lvl1, lvl2, lvl3, cleaning)
//   menu            out  registered menu pulse
//   power_on        out  registered power level
//   btn_mode_smoke  out  [3:0] latched one-hot mode (0000 when none)
//   long_press      out  one-tick pulse on every power_on toggle
//   dbg_state       out  [1:0] menu FSM state (IDLE=0, HELD=1, LONG=2, PULSE=3)
//
// Handshake: none. All inputs are free-running levels; all outputs are
// registered levels/pulses valid for the whole tick after the edge.
// -----------------------------------------------------------------------------
module hood_button_encoder #(
  parameter int DEBOUNCE_TICKS   = 3,
  parameter int LONG_PRESS_TICKS = 300,
  parameter int MENU_PULSE_TICKS = 4
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic       btn_menu_raw,
  input  logic [3:0] btn_mode_raw,
  output logic       menu,
  output logic       power_on,
  output logic [3:0] btn_mode_smoke,
  output logic       long_press,
  output logic [1:0] dbg_state
);

  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W  = $clog2(LONG_PRESS_TICKS + 1);
  localparam int PULSE_W = $clog2(MENU_PULSE_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_LONG  = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  // Bit 0 is the menu button, bits 4:1 are the mode buttons.
  logic [4:0] raw;
  assign raw = {btn_mode_raw, btn_menu_raw};

  // ---------------------------------------------------------------------------
  // Synchronizers and debouncers
  // ---------------------------------------------------------------------------
  logic [4:0]            sync1_q, sync1_d;
  logic [4:0]            sync2_q, sync2_d;
  logic [4:0]            deb_q, deb_d;
  logic [4:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
        // This edge is the DEBOUNCE_TICKS-th consecutive differing sample.
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Menu arming: after reset the menu button must first be seen released
  // (once the synchronizer pipeline has refilled) before a rise may act, so a
  // button held through reset cannot start a press on its own.
  // ---------------------------------------------------------------------------
  logic [1:0] settle_q, settle_d;
  logic       arm_q, arm_d;

  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    arm_d    = arm_q | ((settle_q == 2'd2) && !sync2_q[0]);
  end

  // ---------------------------------------------------------------------------
  // Menu FSM
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic                 menu_q, menu_d;
  logic                 power_q, power_d;
  logic                 long_q, long_d;
  logic                 menu_rise;

  // The rise is taken on the same edge the debouncer commits it, so the
  // power toggle lands exactly LONG_PRESS_TICKS edges after the debounced rise.
  assign menu_rise = deb_d[0] & ~deb_q[0] & arm_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = pulse_q;
    menu_d  = 1'b0;
    power_d = power_q;
    long_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (menu_rise) begin
          state_d = S_HELD;
          hold_d  = '0;
        end
      end
      S_HELD: begin
        if (!deb_q[0]) begin
          if (power_q) begin
            state_d = S_PULSE;
            pulse_d = '0;
            menu_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hold_q == HOLD_W'(LONG_PRESS_TICKS - 1)) begin
          power_d = ~power_q;
          long_d  = 1'b1;
          state_d = S_LONG;
        end else if (hold_q != HOLD_W'(LONG_PRESS_TICKS)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_LONG: begin
        if (!deb_q[0]) begin
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        if (pulse_q == PULSE_W'(MENU_PULSE_TICKS - 1)) begin
          state_d = S_IDLE;
        end else begin
          pulse_d = pulse_q + PULSE_W'(1);
          menu_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Mode latch
  // ---------------------------------------------------------------------------
  logic [3:0] mode_prev_q, mode_prev_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] mode_deb;
  logic [3:0] mode_rise;
  logic       mode_clean;

  assign mode_deb  = deb_q[4:1];
  assign mode_rise = mode_deb & ~mode_prev_q;
  // Exactly one bit rose and it is the only bit currently held.
  assign mode_clean = (mode_rise != 4'd0) &&
                      ((mode_rise & (mode_rise - 4'd1)) == 4'd0) &&
                      (mode_deb == mode_rise);

  always_comb begin
    mode_prev_d = mode_deb;
    mode_d      = mode_q;
    if (power_q && mode_clean) begin
      mode_d = mode_rise;
    end
    if (power_q && !power_d) begin
      mode_d = 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      db_cnt_q    <= '0;
      settle_q    <= '0;
      arm_q       <= 1'b0;
      state_q     <= S_IDLE;
      hold_q      <= '0;
      pulse_q     <= '0;
      menu_q      <= 1'b0;
      power_q     <= 1'b0;
      long_q      <= 1'b0;
      mode_prev_q <= '0;
      mode_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      settle_q    <= settle_d;
      arm_q       <= arm_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      pulse_q     <= pulse_d;
      menu_q      <= menu_d;
      power_q     <= power_d;
      long_q      <= long_d;
      mode_prev_q <= mode_prev_d;
      mode_q      <= mode_d;
    end
  end

  assign menu           = menu_q;
  assign power_on       = power_q;
  assign btn_mode_smoke = mode_q;
  assign long_press     = long_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_hood_button_encoder.sv
// -----------------------------------------------------------------------------
// tb_hood_button_encoder
//
// Drives the hood button encoder with scripted and randomized button activity
// and compares every tick against a timestamp-based reference model of the
// button rules (sample window debounce, press start time, pulse window).
// -----------------------------------------------------------------------------
module tb_hood_button_encoder;

  localparam int D = 3;
  localparam int L = 300;
  localparam int P = 4;

  logic       clk_100Hz = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_menu_raw = 1'b0;
  logic [3:0] btn_mode_raw = 4'd0;
  logic       menu, power_on, long_press;
  logic [3:0] btn_mode_smoke;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  hood_button_encoder #(
    .DEBOUNCE_TICKS(D), .LONG_PRESS_TICKS(L), .MENU_PULSE_TICKS(P)
  ) dut (
    .clk_100Hz(clk_100Hz), .reset(reset),
    .btn_menu_raw(btn_menu_raw), .btn_mode_raw(btn_mode_raw),
    .menu(menu), .power_on(power_on), .btn_mode_smoke(btn_mode_smoke),
    .long_press(long_press), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk_100Hz = ~clk_100Hz;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_t;
  logic [4:0] m_hist[$];   // raw samples still travelling the 2-stage pipe
  logic [4:0] m_win[$];    // last D samples seen by the debouncer
  logic [4:0] m_deb, m_deb_prev;
  logic       m_armed, m_held, m_long_done;
  int         m_press_t, m_pulse_begin, m_pulse_stop;
  logic       m_menu, m_power, m_long;
  logic [3:0] m_mode;

  task automatic model_reset();
    m_t = 0;
    m_hist.delete(); m_hist.push_back(5'd0); m_hist.push_back(5'd0);
    m_win.delete();
    m_deb = 5'd0; m_deb_prev = 5'd0;
    m_armed = 1'b0; m_held = 1'b0; m_long_done = 1'b0;
    m_press_t = 0; m_pulse_begin = -10; m_pulse_stop = -10;
    m_menu = 1'b0; m_power = 1'b0; m_long = 1'b0; m_mode = 4'd0;
  endtask

  task automatic model_edge(input logic [4:0] raw);
    logic [4:0] seen, deb_old, rise5;
    logic [3:0] cur, prv, rise;
    logic       pwr_old, all_diff;
    m_t++;
    m_hist.push_back(raw);
    seen = m_hist.pop_front();
    m_win.push_back(seen);
    if (m_win.size() > D) void'(m_win.pop_front());
    deb_old = m_deb;
    cur = m_deb[4:1];
    prv = m_deb_prev[4:1];
    // a bit flips once the last D samples all disagree with it
    if (m_win.size() == D) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == deb_old[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~deb_old[b];
      end
    end
    m_deb_prev = deb_old;
    pwr_old = m_power;
    m_long  = 1'b0;
    rise = cur & ~prv;
    if (pwr_old && $countones(rise) == 1 && cur == rise) m_mode = rise;
    rise5 = m_deb & ~deb_old;
    if (m_t <= m_pulse_stop) begin
      // pulse in progress: menu activity ignored
    end else if (m_held) begin
      if (!deb_old[0]) begin
        m_held = 1'b0;
        if (!m_long_done && pwr_old) begin
          m_pulse_begin = m_t;
          m_pulse_stop  = m_t + P;
        end
      end else if (!m_long_done && m_t == m_press_t + L) begin
        m_power = ~m_power;
        m_long = 1'b1;
        m_long_done = 1'b1;
      end
    end else if (m_armed && rise5[0]) begin
      m_held = 1'b1;
      m_press_t = m_t;
      m_long_done = 1'b0;
    end
    m_menu = (m_t >= m_pulse_begin) && (m_t < m_pulse_stop);
    if (pwr_old && !m_power) m_mode = 4'd0;
    if (m_t >= 3 && !seen[0]) m_armed = 1'b1;
  endtask

  function automatic logic [6:0] exp_vec();
    return {m_menu, m_power, m_long, m_mode};
  endfunction

  logic [6:0] obs;
  assign obs = {menu, power_on, long_press, btn_mode_smoke};

  // driver: one tick, model advanced on the same edge, sample 1 unit later
  task automatic step();
    @(posedge clk_100Hz);
    if (reset) model_reset();
    else model_edge({btn_mode_raw, btn_menu_raw});
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      btn_menu_raw = 1'($urandom_range(0, 1));
      btn_mode_raw = 4'($urandom_range(0, 15));
      step();
      n_vec++;
      if (obs !== 7'd0 || dbg_state !== 2'd0) begin
        n_err++;
        $display("FAIL reset_state obs=%b state=%0d required=0000000 state 0", obs, dbg_state);
      end
    end
    btn_menu_raw = 1'b0; btn_mode_raw = 4'd0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL post_reset t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
  endtask

  task automatic test_short_off();
    btn_menu_raw = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 50) btn_menu_raw = 1'b0;
      step();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL short_off t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (power_on !== 1'b0 || menu !== 1'b0) begin
      n_err++;
      $display("FAIL short_off_final power=%b menu=%b required 0 0", power_on, menu);
    end
  endtask

  task automatic test_long_on();
    int first_long = -1;
    int n_long = 0;
    int n_menu = 0;
    btn_menu_raw = 1'b1;
    for (int k = 1; k <= 390; k++) begin
      if (k == 351) btn_menu_raw = 1'b0;
      step();
      if (long_press) begin
        n_long++;
        if (first_long < 0) first_long = k;
      end
      if (menu) n_menu++;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL long_on t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (first_long !== 305 || n_long !== 1 || n_menu !== 0 || power_on !== 1'b1) begin
      n_err++;
      $display("FAIL long_on_timing edge=%0d pulses=%0d menu_ticks=%0d power=%b required 305 1 0 1",
               first_long, n_long, n_menu, power_on);
    end
  endtask

  task automatic test_short_on();
    int len = $urandom_range(20, 200);
    int first = -1;
    int cnt = 0;
    btn_menu_raw = 1'b1;
    repeat (len) begin
      step();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL short_on_hold t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    btn_menu_raw = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (menu) begin
        cnt++;
        if (first < 0) first = k;
      end
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL short_on_rel t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (first !== 6 || cnt !== P) begin
      n_err++;
      $display("FAIL short_on_pulse start=%0d width=%0d required 6 %0d", first, cnt, P);
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    logic prev_menu = 1'b0;
    // 2-tick glitch, then a 1-tick glitch of random placement
    for (int i = 0; i < 50; i++) begin
      btn_menu_raw = (i < 2) || (i == 20 + $urandom_range(0, 5));
      step();
      if (menu) rises++;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (rises !== 0) begin
      n_err++;
      $display("FAIL glitch_menu menu_ticks=%0d required 0", rises);
    end
    // bouncing press then stable hold and release: exactly one pulse
    rises = 0;
    for (int i = 0; i < 90; i++) begin
      if (i < 10) btn_menu_raw = (i % 2 == 0);
      else btn_menu_raw = (i < 50);
      step();
      if (menu && !prev_menu) rises++;
      prev_menu = menu;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL bounce t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (rises !== 1) begin
      n_err++;
      $display("FAIL bounce_actions pulses=%0d required 1", rises);
    end
  endtask

  task automatic test_modes();
    logic [3:0] st1[5] = '{4'b0100, 4'b0011, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] st2[5] = '{4'b0100, 4'b0011, 4'b1000, 4'b1000, 4'b0011};
    logic [3:0] res[5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    for (int e = 0; e < 11; e++) begin
      logic [3:0] a, b;
      if (e < 5) begin a = st1[e]; b = st2[e]; end
      else begin a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); end
      for (int i = 0; i < 55; i++) begin
        btn_mode_raw = (i < 20) ? a : (i < 40) ? b : 4'd0;
        step();
        n_vec++;
        if (obs !== exp_vec()) begin
          n_err++;
          $display("FAIL modes e=%0d t=%0d obs=%b required=%b", e, m_t, obs, exp_vec());
        end
      end
      if (e < 5) begin
        n_vec++;
        if (btn_mode_smoke !== res[e]) begin
          n_err++;
          $display("FAIL mode_latch e=%0d got=%b required=%b", e, btn_mode_smoke, res[e]);
        end
      end
    end
    // long press turns power off and clears the mode
    for (int i = 0; i < 360; i++) begin
      btn_menu_raw = (i < 330);
      step();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL power_off t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (power_on !== 1'b0 || btn_mode_smoke !== 4'd0) begin
      n_err++;
      $display("FAIL power_off_final power=%b mode=%b required 0 0000", power_on, btn_mode_smoke);
    end
    // presses while off are ignored
    for (int i = 0; i < 40; i++) begin
      btn_mode_raw = (i < 20) ? 4'b0010 : 4'd0;
      step();
    end
    n_vec++;
    if (btn_mode_smoke !== 4'd0) begin
      n_err++;
      $display("FAIL mode_while_off got=%b required=0000", btn_mode_smoke);
    end
  endtask

  task automatic test_reset_mid_press();
    btn_menu_raw = 1'b1;
    repeat (205) step();
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (obs !== 7'd0) begin
      n_err++;
      $display("FAIL reset_abort obs=%b required=0000000", obs);
    end
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      n_vec++;
      if (obs !== exp_vec() || power_on !== 1'b0) begin
        n_err++;
        $display("FAIL held_after_reset t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    for (int i = 0; i < 380; i++) begin
      btn_menu_raw = (i >= 30) && (i < 350);
      step();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL repress t=%0d obs=%b required=%b", m_t, obs, exp_vec());
      end
    end
    n_vec++;
    if (power_on !== 1'b1) begin
      n_err++;
      $display("FAIL repress_power got=%b required=1", power_on);
    end
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 10; e++) begin
      int len = ($urandom_range(0, 3) == 0) ? $urandom_range(295, 310) : $urandom_range(1, 80);
      int gap = $urandom_range(1, 20);
      logic [3:0] mb = 4'($urandom_range(0, 15));
      int mlen = $urandom_range(1, 30);
      for (int i = 0; i < len + gap; i++) begin
        btn_menu_raw = (i < len);
        btn_mode_raw = (i >= gap && i < gap + mlen) ? mb : 4'd0;
        step();
        n_vec++;
        if (obs !== exp_vec()) begin
          n_err++;
          $display("FAIL back_to_back e=%0d t=%0d obs=%b required=%b", e, m_t, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_off();
    test_long_on();
    test_short_on();
    test_glitch();
    test_modes();
    test_reset_mid_press();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hood_button_encoder.md
HOOD_BUTTON_ENCODER -- requirements
Module: hood_button_encoder

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 3: consecutive differing synchronized samples required to change a debounced input.
REQ-002 Parameter LONG_PRESS_TICKS, default 300: menu hold length (3 s) that toggles power.
REQ-003 Parameter MENU_PULSE_TICKS, default 4: high width of the emitted menu pulse.
REQ-004 clk_100Hz  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_menu_raw  input  1  raw, bouncy menu push-button, active-high.
REQ-007 btn_mode_raw  input  4  raw mode buttons: bit0 lvl1, bit1 lvl2, bit2 lvl3, bit3 cleaning; active-high.
REQ-008 menu  output  1  clean menu level for the hood controller; high only during a short-press pulse.
REQ-009 power_on  output  1  power level; toggled by a long menu press.
REQ-010 btn_mode_smoke  output  4  latched one-hot mode selection (0000, 0001, 0010, 0100, 1000 only).
REQ-011 long_press  output  1  one-tick pulse on every power_on toggle.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer, then a per-bit debouncer: counter clears when synced equals debounced; the debounced bit takes the synced value on the edge where DEBOUNCE_TICKS consecutive differing samples are reached.
REQ-013 Raw-to-debounced latency SHALL be exactly DEBOUNCE_TICKS+2 edges for a clean transition; pulses shorter than DEBOUNCE_TICKS ticks SHALL never reach the debounced value.
REQ-014 Menu FSM states: IDLE, HELD, LONG, PULSE.
REQ-015 IDLE: on debounced-menu rising edge -> HELD, hold_cnt=0; a menu already high in IDLE (no edge) is ignored.
REQ-016 HELD: hold_cnt increments each tick; when it reaches LONG_PRESS_TICKS-1 with menu still high -> toggle power_on, pulse long_press, go LONG (toggle occurs exactly LONG_PRESS_TICKS edges after debounced rise).
REQ-017 HELD with debounced menu falling before the long threshold: power_on=1 -> PULSE; power_on=0 -> IDLE (short press while off ignored).
REQ-018 LONG: no menu pulse; remain until debounced menu low, then IDLE; further holding SHALL NOT toggle again.
REQ-019 PULSE: menu registered high for exactly MENU_PULSE_TICKS edges starting the edge after debounced fall, then IDLE; menu activity during PULSE ignored.
REQ-020 Mode latch: on a tick where exactly one debounced mode bit rises and no other mode bit is debounced-high, btn_mode_smoke SHALL load that one-hot value the next edge.
REQ-021 Simultaneous rises on 2+ bits, or a rise while another bit is held, SHALL leave btn_mode_smoke unchanged.
REQ-022 Mode presses while power_on=0 SHALL be ignored; on the edge power_on toggles 1->0, btn_mode_smoke SHALL clear to 0000.
REQ-023 Re-pressing the currently latched mode SHALL keep it unchanged (no toggle-off).
REQ-024 hold_cnt width SHALL cover LONG_PRESS_TICKS and saturate; no wrap-around.

Reset
REQ-025 While reset=1: menu=0, power_on=0, btn_mode_smoke=0000, long_press=0, FSM=IDLE, synchronizers, debounced values and all counters 0.
REQ-026 Reset asserted mid-press or mid-pulse SHALL abort immediately; after release a still-held button requires a fresh debounced rising edge to act.

Verification (DEBOUNCE_TICKS=3, LONG_PRESS_TICKS=300, MENU_PULSE_TICKS=4)
REQ-027 Power off, menu raw high 50 ticks -> menu stays 0, power_on stays 0.
REQ-028 Menu raw high 350 ticks -> power_on=1 and long_press=1 for one tick at edge 305 after press; no menu pulse on release.
REQ-029 Power on, menu raw high 50 ticks then low -> menu high exactly 4 ticks, starting 6 edges after raw release.
REQ-030 Menu raw 2-tick glitch, and bouncing 1-tick toggles for 10 ticks before stable -> no spurious debounced edge; single action only.
REQ-031 Power on: press bit2 -> 0100; press bit0+bit1 same tick -> stays 0100; press bit3 alone -> 1000; long press off -> power_on=0, btn_mode_smoke=0000.
REQ-032 Reset pulse at hold tick 200 of a long press, button kept held -> all outputs 0, no toggle after reset release until button is released and pressed again.
